// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, FSM states, error cause codes
// and the request legality/alignment check used at accept time.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_BUS      = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    // Illegal encodings win over misalignment.
    function automatic logic [1:0] check_access(
        input logic       ld,
        input logic       st,
        input logic [2:0] f3,
        input logic [1:0] a_lo
    );
        logic illegal;
        logic misalign;
        illegal  = (ld == st)
                || (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
                || (st && (f3 >= 3'd3));
        misalign = ((f3[1:0] == 2'd1) && a_lo[0])
                || ((f3[1:0] == 2'd2) && (a_lo != 2'd0));
        if (illegal) begin
            return ERR_ILLEGAL;
        end
        if (misalign) begin
            return ERR_MISALIGN;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication + byte enables, and
// load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_r_data,
    output logic [BE_W-1:0] o_be_c,
    output logic [XLEN-1:0] o_w_data_c,
    output logic [XLEN-1:0] o_load_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    always_comb begin
        o_be_c     = 4'b1111;
        o_w_data_c = i_store_data;
        case (i_funct3[1:0])
            2'd0: begin
                o_be_c     = 4'b0001 << i_addr_lo;
                o_w_data_c = {4{i_store_data[7:0]}};
            end
            2'd1: begin
                o_be_c     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_w_data_c = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // funct3[2] selects zero extension (LBU/LHU).
    always_comb begin
        w_byte        = i_r_data[{i_addr_lo, 3'b000} +: 8];
        w_half        = i_addr_lo[1] ? i_r_data[31:16] : i_r_data[15:0];
        w_unsigned    = i_funct3[2];
        o_load_data_c = i_r_data;
        case (i_funct3[1:0])
            2'd0: o_load_data_c = w_unsigned ? {24'd0, w_byte}
                                             : {{24{w_byte[7]}}, w_byte};
            2'd1: o_load_data_c = w_unsigned ? {16'd0, w_half}
                                             : {{16{w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: checks the request, issues one word-aligned DM
// access and returns extended load data. LSU_TIMEOUT_EN adds a WAIT timeout.
module load_store_unit
    import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
)
`endif
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_cause,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] data_addr,
    output logic [XLEN-1:0] W_data,
    output logic [BE_W-1:0] data_be,
    output logic            data_REn,
    output logic            data_WEn,
    input  logic [XLEN-1:0] R_data,
    input  logic            D_valid,
    input  logic            D_err
);

    lsu_state_t      r_state,     w_state;
    logic [1:0]      r_addr_lo,   w_addr_lo;
    logic [2:0]      r_f3,        w_f3;
    logic            r_is_load,   w_is_load;
    logic            r_busy,      w_busy;
    logic            r_done,      w_done;
    logic            r_err,       w_err;
    logic [1:0]      r_cause,     w_cause;
    logic [XLEN-1:0] r_load_data, w_load_data;
    logic [XLEN-1:0] r_data_addr, w_data_addr;
    logic [XLEN-1:0] r_w_data,    w_w_data;
    logic [BE_W-1:0] r_be,        w_be;
    logic            r_ren,       w_ren;
    logic            r_wen,       w_wen;
`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt, w_cnt;
`endif

    logic [1:0]      w_check;
    logic [2:0]      w_sel_f3;
    logic [1:0]      w_sel_lo;
    logic [BE_W-1:0] w_be_c;
    logic [XLEN-1:0] w_st_c;
    logic [XLEN-1:0] w_ld_c;

    // Lane logic sees the live request in IDLE and the latched one afterwards.
    assign w_sel_f3 = (r_state == S_IDLE) ? funct3    : r_f3;
    assign w_sel_lo = (r_state == S_IDLE) ? addr[1:0] : r_addr_lo;
    assign w_check  = check_access(is_load, is_store, funct3, addr[1:0]);

    lsu_align u_align (
        .i_funct3      (w_sel_f3),
        .i_addr_lo     (w_sel_lo),
        .i_store_data  (store_data),
        .i_r_data      (R_data),
        .o_be_c        (w_be_c),
        .o_w_data_c    (w_st_c),
        .o_load_data_c (w_ld_c)
    );

    always_comb begin
        w_state     = r_state;
        w_addr_lo   = r_addr_lo;
        w_f3        = r_f3;
        w_is_load   = r_is_load;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_cause     = ERR_NONE;
        w_load_data = r_load_data;
        w_data_addr = '0;
        w_w_data    = '0;
        w_be        = '0;
        w_ren       = 1'b0;
        w_wen       = 1'b0;
`ifdef LSU_TIMEOUT_EN
        w_cnt       = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_addr_lo = addr[1:0];
                    w_f3      = funct3;
                    w_is_load = is_load;
                    if (w_check == ERR_NONE) begin
                        w_state     = S_REQ;
                        w_busy      = 1'b1;
                        w_data_addr = {addr[XLEN-1:2], 2'b00};
                        if (is_load) begin
                            w_ren = 1'b1;
                            w_be  = 4'b1111;
                        end else begin
                            w_wen    = 1'b1;
                            w_be     = w_be_c;
                            w_w_data = w_st_c;
                        end
                    end else begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                        w_err   = 1'b1;
                        w_cause = w_check;
                    end
                end
            end
            S_REQ: begin
                w_state = S_WAIT;
                w_busy  = 1'b1;
`ifdef LSU_TIMEOUT_EN
                w_cnt   = '0;
`endif
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (D_valid) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    if (D_err) begin
                        w_err   = 1'b1;
                        w_cause = ERR_BUS;
                    end else if (r_is_load) begin
                        w_load_data = w_ld_c;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                    w_cause = ERR_BUS;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr_lo   <= '0;
            r_f3        <= '0;
            r_is_load   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cause     <= ERR_NONE;
            r_load_data <= '0;
            r_data_addr <= '0;
            r_w_data    <= '0;
            r_be        <= '0;
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_addr_lo   <= w_addr_lo;
            r_f3        <= w_f3;
            r_is_load   <= w_is_load;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
            r_cause     <= w_cause;
            r_load_data <= w_load_data;
            r_data_addr <= w_data_addr;
            r_w_data    <= w_w_data;
            r_be        <= w_be;
            r_ren       <= w_ren;
            r_wen       <= w_wen;
`ifdef LSU_TIMEOUT_EN
            r_cnt       <= w_cnt;
`endif
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_cause = r_cause;
    assign load_data = r_load_data;
    assign data_addr = r_data_addr;
    assign W_data    = r_w_data;
    assign data_be   = r_be;
    assign data_REn  = r_ren;
    assign data_WEn  = r_wen;

endmodule
